mmio_input_debouncer: RTL and testbench

// - Conditions raw devboard push-button levels before they reach the core's MMIO input port (mmioInputs[4]).
// - Per channel: 2-flop synchronizer, stability-counter debounce, one-cycle press/release pulses, sticky press flag.
// - The core clears a sticky flag with a write-1-to-clear strobe taken from its MMIO output side.
// - Sits between the inverted button pins and the core; clocked on the core's clock domain.

---
 rtl/jzjcoref_io_pkg.sv | 13 +
 rtl/debounce_channel.sv | 83 ++++++++
 rtl/mmio_input_debouncer.sv | 54 +++++
 tb/tb_mmio_input_debouncer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/jzjcoref_io_pkg.sv
// rtl/jzjcoref_io_pkg.sv - shared constants and types for the MMIO input conditioning path
package jzjcoref_io_pkg;

   localparam int STATUS_LEVEL_LSB  = 0;
   localparam int STATUS_STICKY_LSB = 8;
   localparam int MAX_MMIO_INPUTS   = 8;

   typedef enum logic {
      DB_STABLE,
      DB_CHANGING
   } debounceState_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchronizer, stability-counter debounce and edge pulses
module debounce_channel
   import jzjcoref_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic rawIn,
   output logic debounced,
   output logic pressPulse,
   output logic releasePulse,
   output logic pressEvent
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic           s1, s2;
   debounceState_t state, stateNext;
   logic [CW-1:0]  count, countNext;
   logic           accept;
   logic           releaseEvent;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1           <= 1'b0;
         s2           <= 1'b0;
         state        <= DB_STABLE;
         count        <= '0;
         debounced    <= 1'b0;
         pressPulse   <= 1'b0;
         releasePulse <= 1'b0;
      end else begin
         s1           <= rawIn;
         s2           <= s1;
         state        <= stateNext;
         count        <= countNext;
         debounced    <= accept ? s2 : debounced;
         pressPulse   <= pressEvent;
         releasePulse <= releaseEvent;
      end
   end

   // Any sample matching the accepted level throws away the count so far.
   always_comb begin
      stateNext = state;
      countNext = count;
      accept    = 1'b0;
      case (state)
         DB_STABLE: begin
            countNext = '0;
            if (s2 != debounced) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  accept = 1'b1;
               end else begin
                  stateNext = DB_CHANGING;
                  countNext = CW'(1);
               end
            end
         end
         DB_CHANGING: begin
            if (s2 == debounced) begin
               stateNext = DB_STABLE;
               countNext = '0;
            end else if (count == LAST_COUNT) begin
               accept    = 1'b1;
               stateNext = DB_STABLE;
               countNext = '0;
            end else begin
               countNext = count + CW'(1);
            end
         end
         default: begin
            stateNext = DB_STABLE;
            countNext = '0;
         end
      endcase
      pressEvent   = accept & s2;
      releaseEvent = accept & ~s2;
   end

endmodule

// File: rtl/mmio_input_debouncer.sv
// rtl/mmio_input_debouncer.sv - debounced button levels, pulses and sticky press flags for MMIO
module mmio_input_debouncer
   import jzjcoref_io_pkg::*;
#(
   parameter int NUM_INPUTS      = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_INPUTS-1:0] rawIn,
   input  logic                  clearStrobe,
   input  logic [NUM_INPUTS-1:0] clearMask,
   output logic [NUM_INPUTS-1:0] debounced,
   output logic [NUM_INPUTS-1:0] pressPulse,
   output logic [NUM_INPUTS-1:0] releasePulse,
   output logic [NUM_INPUTS-1:0] sticky,
   output logic [31:0]           statusWord
);

   logic [NUM_INPUTS-1:0] pressEvent;
   logic [NUM_INPUTS-1:0] clearBits;

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_channel
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_channel (
         .clock        (clock),
         .reset        (reset),
         .rawIn        (rawIn[i]),
         .debounced    (debounced[i]),
         .pressPulse   (pressPulse[i]),
         .releasePulse (releasePulse[i]),
         .pressEvent   (pressEvent[i])
      );
   end

   assign clearBits = {NUM_INPUTS{clearStrobe}} & clearMask;

   // A press landing on the same edge as its clear must survive.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sticky <= '0;
      end else begin
         sticky <= (sticky & ~clearBits) | pressEvent;
      end
   end

   always_comb begin
      statusWord = '0;
      statusWord[STATUS_LEVEL_LSB +: NUM_INPUTS]  = debounced;
      statusWord[STATUS_STICKY_LSB +: NUM_INPUTS] = sticky;
   end

endmodule

// File: tb/tb_mmio_input_debouncer.sv
// tb/tb_mmio_input_debouncer.sv - randomized and directed checks against a sample-window model
module tb_mmio_input_debouncer;

   localparam int NI = 4;
   localparam int DC = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [NI-1:0] rawIn;
   logic          clearStrobe;
   logic [NI-1:0] clearMask;
   logic [NI-1:0] debounced, pressPulse, releasePulse, sticky;
   logic [31:0]   statusWord;

   int vectors = 0;
   int miscompares = 0;

   logic [NI-1:0] hist[$];
   logic [NI-1:0] m_deb, m_press, m_rel, m_sticky;

   mmio_input_debouncer #(
      .NUM_INPUTS      (NI),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .rawIn        (rawIn),
      .clearStrobe  (clearStrobe),
      .clearMask    (clearMask),
      .debounced    (debounced),
      .pressPulse   (pressPulse),
      .releasePulse (releasePulse),
      .sticky       (sticky),
      .statusWord   (statusWord)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_deb    = '0;
      m_press  = '0;
      m_rel    = '0;
      m_sticky = '0;
   endtask

   function automatic logic sample_at(input int idx, input int ch);
      logic [NI-1:0] w;
      if (idx < 0) return 1'b0;
      w = hist[idx];
      return w[ch];
   endfunction

   // A level is accepted once the DC samples that reached the second sync flop all disagree with it.
   task automatic model_edge(input logic [NI-1:0] raw, input logic cs, input logic [NI-1:0] cm);
      int n;
      logic [NI-1:0] nd;
      n = hist.size();
      nd = m_deb;
      m_press = '0;
      m_rel = '0;
      for (int ch = 0; ch < NI; ch++) begin
         bit all_differ;
         all_differ = 1'b1;
         for (int j = 2; j <= DC + 1; j++) begin
            if (sample_at(n - j, ch) == m_deb[ch]) all_differ = 1'b0;
         end
         if (all_differ) begin
            nd[ch] = ~m_deb[ch];
            if (nd[ch]) m_press[ch] = 1'b1;
            else        m_rel[ch]   = 1'b1;
         end
      end
      m_deb = nd;
      m_sticky = (m_sticky & ~(cs ? cm : '0)) | m_press;
      hist.push_back(raw);
      if (hist.size() > 16) void'(hist.pop_front());
   endtask

   task automatic compare_all();
      logic [31:0] exp_word;
      exp_word = {16'h0, 4'h0, m_sticky, 4'h0, m_deb};
      check("debounced",    {28'h0, debounced},    {28'h0, m_deb});
      check("pressPulse",   {28'h0, pressPulse},   {28'h0, m_press});
      check("releasePulse", {28'h0, releasePulse}, {28'h0, m_rel});
      check("sticky",       {28'h0, sticky},       {28'h0, m_sticky});
      check("statusWord",   statusWord,            exp_word);
   endtask

   task automatic step(input logic [NI-1:0] raw, input logic cs, input logic [NI-1:0] cm);
      rawIn       = raw;
      clearStrobe = cs;
      clearMask   = cm;
      @(posedge clock);
      model_edge(raw, cs, cm);
      #1;
      compare_all();
   endtask

   initial begin
      int hold[NI];
      logic [NI-1:0] level;
      logic t;

      reset = 1'b1;
      rawIn = '0;
      clearStrobe = 1'b0;
      clearMask = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("reset_status", statusWord, 32'h0);
      check("reset_debounced", {28'h0, debounced}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Async reset in the middle of a count, away from any clock edge.
      repeat (3) step(4'hF, 1'b0, 4'h0);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_status", statusWord, 32'h0);
      check("async_rst_pulses", {24'h0, pressPulse, releasePulse}, 32'h0);
      #1;
      reset = 1'b0;
      rawIn = '0;
      model_reset();
      repeat (8) step(4'h0, 1'b0, 4'h0);
      check("post_reset_status", statusWord, 32'h0);

      // Clean press on channel 0: accepted on the sixth edge of the step sequence (N+5).
      repeat (5) step(4'h1, 1'b0, 4'h0);
      check("press_n4_level", {28'h0, debounced}, 32'h0);
      step(4'h1, 1'b0, 4'h0);
      check("press_n5_pulse", {28'h0, pressPulse}, 32'h1);
      check("press_n5_status", statusWord, 32'h0000_0101);
      step(4'h1, 1'b0, 4'h0);
      check("press_pulse_one_cycle", {28'h0, pressPulse}, 32'h0);

      // Bounce channel 2 faster than the debounce window.
      t = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c % 3 == 0) t = ~t;
         step({1'b0, t, 2'b01}, 1'b0, 4'h0);
      end
      repeat (6) step(4'h1, 1'b0, 4'h0);
      check("bounce_debounced", {28'h0, debounced}, 32'h1);
      check("bounce_sticky", {28'h0, sticky}, 32'h1);

      repeat (5) step(4'h0, 1'b0, 4'h0);
      step(4'h0, 1'b0, 4'h0);
      check("release_pulse", {28'h0, releasePulse}, 32'h1);
      check("release_status", statusWord, 32'h0000_0100);

      step(4'h0, 1'b1, 4'h1);
      check("clear_sticky", statusWord, 32'h0);

      // Clear arriving on the same edge as a new press: the press wins.
      repeat (5) step(4'h1, 1'b0, 4'h0);
      step(4'h1, 1'b1, 4'h1);
      check("clear_vs_press", statusWord, 32'h0000_0101);

      repeat (7) step(4'h0, 1'b0, 4'h0);
      step(4'h0, 1'b1, 4'hF);
      check("all_clear", statusWord, 32'h0);

      repeat (5) step(4'hA, 1'b0, 4'h0);
      step(4'hA, 1'b0, 4'h0);
      check("multi_press", {28'h0, pressPulse}, 32'hA);
      check("multi_status", statusWord, 32'h0000_0A0A);

      // Random levels with random hold times, plus sporadic clears and masks ignored without strobe.
      level = 4'hA;
      for (int ch = 0; ch < NI; ch++) hold[ch] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int ch = 0; ch < NI; ch++) begin
            if (hold[ch] == 0) begin
               level[ch] = $urandom_range(0, 1);
               hold[ch]  = $urandom_range(1, 9);
            end else begin
               hold[ch]--;
            end
         end
         step(level, ($urandom_range(0, 7) == 0), NI'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
